// File: rtl/swervolf_input_debounce.sv
// Switch/button conditioner: two-flop synchroniser, per-bit hold-counter debounce,
// edge pulses, sticky maskable event flags and a registered interrupt.
module swervolf_input_debounce #(
    parameter int unsigned     WIDTH     = 16,
    parameter int unsigned     DB_CYCLES = 50000,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] i_raw,
    input  logic [WIDTH-1:0] i_clr,
    input  logic [WIDTH-1:0] i_mask,
    output logic [WIDTH-1:0] o_stable,
    output logic [WIDTH-1:0] o_rise,
    output logic [WIDTH-1:0] o_fall,
    output logic [WIDTH-1:0] o_event,
    output logic             o_irq
);

    localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] stable_d;
    logic [WIDTH-1:0] rise_d;
    logic [WIDTH-1:0] fall_d;
    logic [WIDTH-1:0] event_d;
    logic             irq_d;

    // Per-bit debounce: count consecutive mismatching cycles, accept on the last one
    always_comb begin
        stable_d = o_stable;
        rise_d   = '0;
        fall_d   = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            cnt_d[i] = '0;
            if (sync2[i] != o_stable[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    stable_d[i] = sync2[i];
                    rise_d[i]   = sync2[i];
                    fall_d[i]   = ~sync2[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Set from the registered pulse and OR'd in after the clear, so a colliding clear cannot lose it
    always_comb begin
        event_d = (o_event & ~i_clr) | o_rise | o_fall;
        irq_d   = |(o_event & i_mask);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1    <= RESET_VAL;
            sync2    <= RESET_VAL;
            o_stable <= RESET_VAL;
            o_rise   <= '0;
            o_fall   <= '0;
            o_event  <= '0;
            o_irq    <= 1'b0;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1    <= i_raw;
            sync2    <= sync1;
            o_stable <= stable_d;
            o_rise   <= rise_d;
            o_fall   <= fall_d;
            o_event  <= event_d;
            o_irq    <= irq_d;
            for (int i = 0; i < int'(WIDTH); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule

// File: tb/tb_swervolf_input_debounce.sv
// Directed bench for swervolf_input_debounce (WIDTH=16, DB_CYCLES=4); edge pulses are
// scoreboarded with their expected cycle, level/flag outputs are checked inline.
module tb_swervolf_input_debounce;

    logic        clk;
    logic        rstn;
    logic [15:0] i_raw;
    logic [15:0] i_clr;
    logic [15:0] i_mask;
    logic [15:0] o_stable;
    logic [15:0] o_rise;
    logic [15:0] o_fall;
    logic [15:0] o_event;
    logic        o_irq;

    swervolf_input_debounce #(
        .WIDTH     (16),
        .DB_CYCLES (4),
        .RESET_VAL (16'h0000)
    ) dut (
        .clk      (clk),
        .rstn     (rstn),
        .i_raw    (i_raw),
        .i_clr    (i_clr),
        .i_mask   (i_mask),
        .o_stable (o_stable),
        .o_rise   (o_rise),
        .o_fall   (o_fall),
        .o_event  (o_event),
        .o_irq    (o_irq)
    );

    typedef struct packed {
        int unsigned cyc;
        logic [15:0] rise;
        logic [15:0] fall;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned cyc;
    int          n_checks;
    int          n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic nc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int unsigned at, input logic [15:0] r, input logic [15:0] f);
        exp_t e;
        e.cyc  = at;
        e.rise = r;
        e.fall = f;
        exp_q.push_back(e);
    endtask

    // Monitor: every pulse the DUT presents must match the oldest scoreboard entry
    always @(negedge clk) begin
        if (rstn && ((o_rise | o_fall) != 16'h0)) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_pulse @cyc %0d: rise %h fall %h, none expected",
                         cyc, o_rise, o_fall);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.cyc != cyc || e.rise !== o_rise || e.fall !== o_fall) begin
                    n_fail++;
                    $display("FAIL pulse: got cyc %0d rise %h fall %h, expected cyc %0d rise %h fall %h",
                             cyc, o_rise, o_fall, e.cyc, e.rise, e.fall);
                end
            end
        end
    end

    initial begin
        int unsigned c;
        int unsigned d;
        logic [5:0]  bounce;
        cyc      = 0;
        n_checks = 0;
        n_fail   = 0;
        rstn     = 1'b0;
        i_raw    = 16'h0000;
        i_clr    = 16'h0000;
        i_mask   = 16'hFFFF;
        bounce   = 6'b111011;

        nc(3);
        chk("rst_stable", o_stable, 16'h0000);
        chk("rst_rise", o_rise, 16'h0000);
        chk("rst_fall", o_fall, 16'h0000);
        chk("rst_event", o_event, 16'h0000);
        chk("rst_irq", 16'(o_irq), 16'h0000);
        rstn = 1'b1;

        for (int k = 0; k < 100; k++) begin
            nc(1);
            chk("idle_out", o_stable | o_event | o_rise | o_fall, 16'h0000);
            chk("idle_irq", 16'(o_irq), 16'h0000);
        end

        // Clean rise on bit 3
        nc(1);
        c = cyc;
        i_raw[3] = 1'b1;
        push(c + 6, 16'h0008, 16'h0000);
        nc(5);
        chk("b3_stable_early", o_stable, 16'h0000);
        nc(1);
        chk("b3_stable", o_stable, 16'h0008);
        nc(1);
        chk("b3_event", o_event, 16'h0008);
        chk("b3_irq_early", 16'(o_irq), 16'h0000);
        nc(1);
        chk("b3_irq", 16'(o_irq), 16'h0001);
        i_clr = 16'hFFFF;
        nc(1);
        i_clr = 16'h0000;
        chk("b3_event_clr", o_event, 16'h0000);
        nc(1);
        chk("b3_irq_clr", 16'(o_irq), 16'h0000);

        // Bounce on bit 0: 1,1,0,1,1,1 then steady 1
        nc(2);
        c = cyc;
        push(c + 9, 16'h0001, 16'h0000);
        for (int k = 0; k < 6; k++) begin
            i_raw[0] = bounce[k];
            nc(1);
        end
        nc(2);
        chk("b0_stable_early", o_stable & 16'h0001, 16'h0000);
        nc(1);
        chk("b0_stable", o_stable & 16'h0001, 16'h0001);
        nc(2);
        i_clr = 16'hFFFF;
        nc(1);
        i_clr = 16'h0000;

        // Glitch on bit 5: three cycles high, then back low
        nc(2);
        i_raw[5] = 1'b1;
        nc(3);
        i_raw[5] = 1'b0;
        nc(10);
        chk("b5_stable", o_stable & 16'h0020, 16'h0000);
        chk("b5_event", o_event & 16'h0020, 16'h0000);

        // Bit 7: rise, clear, then fall with a clear colliding with the set
        c = cyc;
        i_raw[7] = 1'b1;
        push(c + 6, 16'h0080, 16'h0000);
        nc(7);
        chk("b7_event_rise", o_event, 16'h0080);
        i_clr = 16'h0080;
        nc(1);
        i_clr = 16'h0000;
        chk("b7_event_clr1", o_event, 16'h0000);
        nc(3);
        d = cyc;
        i_raw[7] = 1'b0;
        push(d + 6, 16'h0000, 16'h0080);
        nc(6);
        i_clr = 16'h0080;
        nc(1);
        chk("b7_collision_event", o_event, 16'h0080);
        nc(1);
        i_clr = 16'h0000;
        chk("b7_event_clr2", o_event, 16'h0000);
        chk("b7_irq_hold", 16'(o_irq), 16'h0001);
        nc(1);
        chk("b7_irq_drop", 16'(o_irq), 16'h0000);

        // Masking: events on bits 1 and 2, only bit 1 enabled
        i_mask = 16'h0002;
        nc(2);
        c = cyc;
        i_raw[2:1] = 2'b11;
        push(c + 6, 16'h0006, 16'h0000);
        nc(7);
        chk("mask_event", o_event, 16'h0006);
        nc(1);
        chk("mask_irq", 16'(o_irq), 16'h0001);
        i_clr = 16'h0002;
        nc(1);
        i_clr = 16'h0000;
        chk("mask_event_b1clr", o_event, 16'h0004);
        chk("mask_irq_hold", 16'(o_irq), 16'h0001);
        nc(1);
        chk("mask_irq_drop", 16'(o_irq), 16'h0000);
        chk("mask_event_b2", o_event, 16'h0004);

        // Reset while the bit-4 counter sits at 2
        i_mask = 16'hFFFF;
        nc(2);
        c = cyc;
        i_raw[4] = 1'b1;
        nc(4);
        rstn = 1'b0;
        #1;
        chk("midrst_stable", o_stable, 16'h0000);
        chk("midrst_rise", o_rise, 16'h0000);
        chk("midrst_event", o_event, 16'h0000);
        chk("midrst_irq", 16'(o_irq), 16'h0000);
        nc(2);
        rstn = 1'b1;
        d = cyc;
        push(d + 6, 16'h001F, 16'h0000);
        nc(5);
        chk("post_rst_stable_early", o_stable, 16'h0000);
        nc(1);
        chk("post_rst_stable", o_stable, 16'h001F);

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) nc(1);
        nc(3);
        chk("scoreboard_drained", 16'(exp_q.size()), 16'h0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
